ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset).
- It is the opposite direction of the existing PS/2 keyboard receiver and shares the same open-collector PS2_CLK/DATA_PS2 pins.
- It runs on the 50 MHz system clock.
- Top level ties the pins with tri-state buffers: pin = oe ? 1'b0 : 1'bz. The receiver must ignore line activity while busy=1.

---
 rtl/ps2_host_tx.sv | 192 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the keyboard
// over the shared open-collector PS2_CLK / DATA_PS2 pins (oe=1 pulls low).
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,    // clock held low before the request
    parameter int TIMEOUT_CYCLES = 750000,  // max gap between device clock falls
    parameter int FILTER_LEN     = 8        // equal samples to accept a level (>= 2)
) (
    input  logic       clk,
    input  logic       rstin,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    // The timer also paces the inhibit phase, so size it for the larger of both.
    localparam int TMR_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int TW      = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE, S_DONE, S_ERR
    } state_t;

    // Line 0 is the PS/2 clock, line 1 the PS/2 data.
    logic [1:0] w_raw;
    logic [1:0] w_filt;
    assign w_raw = {ps2_data_in, ps2_clk_in};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cond
            logic                  r_s1;
            logic                  r_s2;
            logic [FILTER_LEN-1:0] r_hist;
            logic                  r_filt;

            // Synchronize the raw pin, then only accept a level seen FILTER_LEN times in a row.
            always_ff @(posedge clk) begin
                if (!rstin) begin
                    r_s1   <= 1'b1;
                    r_s2   <= 1'b1;
                    r_hist <= '1;
                    r_filt <= 1'b1;
                end else begin
                    r_s1   <= w_raw[gi];
                    r_s2   <= r_s1;
                    r_hist <= {r_hist[FILTER_LEN-2:0], r_s2};
                    if (&r_hist) begin
                        r_filt <= 1'b1;
                    end else if (~|r_hist) begin
                        r_filt <= 1'b0;
                    end
                end
            end

            assign w_filt[gi] = r_filt;
        end
    endgenerate

    logic w_clk_f;
    logic w_dat_f;
    logic w_fall;
    logic r_clk_prev;
    assign w_clk_f = w_filt[0];
    assign w_dat_f = w_filt[1];
    assign w_fall  = r_clk_prev & ~w_clk_f;

    state_t          r_state;
    logic [10:0]     r_sh;
    logic [3:0]      r_bitcnt;
    logic [TW-1:0]   r_timer;

    state_t          w_state_next;
    logic [10:0]     w_sh_next;
    logic [3:0]      w_bitcnt_next;
    logic [TW-1:0]   w_timer_next;
    logic            w_timeout;
    logic            w_clk_oe_next;
    logic            w_data_oe_next;
    logic            w_busy_next;

    assign w_timeout = (r_timer == TW'(TIMEOUT_CYCLES - 1));

    // Next-state, frame/bit-counter/timer updates and registered-output decode.
    always_comb begin
        w_state_next  = r_state;
        w_sh_next     = r_sh;
        w_bitcnt_next = r_bitcnt;
        w_timer_next  = r_timer;
        case (r_state)
            S_IDLE: begin
                if (tx_start) begin
                    w_state_next  = S_INHIBIT;
                    w_sh_next     = {1'b1, ~^tx_data, tx_data, 1'b0};
                    w_bitcnt_next = 4'd0;
                    w_timer_next  = '0;
                end
            end
            S_INHIBIT: begin
                if (r_timer == TW'(INHIBIT_CYCLES - 1)) begin
                    w_state_next = S_REQ;
                    w_timer_next = '0;
                end else begin
                    w_timer_next = r_timer + TW'(1);
                end
            end
            S_REQ: begin
                w_state_next = S_SEND;
                w_timer_next = '0;
            end
            S_SEND: begin
                if (w_fall) begin
                    w_timer_next = '0;
                    if (r_bitcnt == 4'd9) begin
                        w_bitcnt_next = 4'd10;
                        w_state_next  = S_ACK;
                    end else begin
                        w_bitcnt_next = r_bitcnt + 4'd1;
                    end
                end else if (w_timeout) begin
                    w_state_next = S_ERR;
                end else begin
                    w_timer_next = r_timer + TW'(1);
                end
            end
            S_ACK: begin
                if (w_fall) begin
                    w_timer_next = '0;
                    w_state_next = w_dat_f ? S_ERR : S_WAIT_IDLE;
                end else if (w_timeout) begin
                    w_state_next = S_ERR;
                end else begin
                    w_timer_next = r_timer + TW'(1);
                end
            end
            S_WAIT_IDLE: begin
                if (w_clk_f && w_dat_f) begin
                    w_state_next = S_DONE;
                end else if (w_fall) begin
                    w_timer_next = '0;
                end else if (w_timeout) begin
                    w_state_next = S_ERR;
                end else begin
                    w_timer_next = r_timer + TW'(1);
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            S_ERR:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase

        // Outputs are decoded from the next state so the pins come straight off flops.
        w_clk_oe_next  = (w_state_next == S_INHIBIT) || (w_state_next == S_REQ);
        w_data_oe_next = (w_state_next == S_REQ) ||
                         ((w_state_next == S_SEND) && !w_sh_next[w_bitcnt_next]);
        w_busy_next    = (w_state_next == S_INHIBIT) || (w_state_next == S_REQ) ||
                         (w_state_next == S_SEND) || (w_state_next == S_ACK) ||
                         (w_state_next == S_WAIT_IDLE);
    end

    // State, datapath and output registers; reset releases both lines immediately.
    always_ff @(posedge clk) begin
        if (!rstin) begin
            r_state     <= S_IDLE;
            r_sh        <= '0;
            r_bitcnt    <= '0;
            r_timer     <= '0;
            r_clk_prev  <= 1'b1;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_sh        <= w_sh_next;
            r_bitcnt    <= w_bitcnt_next;
            r_timer     <= w_timer_next;
            r_clk_prev  <= w_clk_f;
            ps2_clk_oe  <= w_clk_oe_next;
            ps2_data_oe <= w_data_oe_next;
            busy        <= w_busy_next;
            tx_done     <= (w_state_next == S_DONE);
            tx_err      <= (w_state_next == S_ERR);
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a keyboard model clocks frames out of the host,
// decodes them and acks; results are compared with frames built from the
// byte value (start 0, data LSB first, odd parity, stop 1).
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TMO  = 2000;
    localparam int FLT  = 2;
    localparam int HALF = 80;
    // Pin change to the edge where the host acts on the fall: 2 synchronizer
    // flops, FLT history samples, the filtered-level flop, then the FSM edge.
    localparam int COND_LAT = FLT + 4;

    logic       clk = 1'b0;
    logic       rstin;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err;
    logic       dev_clk_low, dev_data_low;
    logic       ps2_clk_pin, ps2_data_pin;

    always #5 clk = ~clk;

    // Open-collector wired-AND of host and keyboard drivers.
    assign ps2_clk_pin  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_pin = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_LEN     (FLT)
    ) dut (
        .clk         (clk),
        .rstin       (rstin),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .ps2_clk_in  (ps2_clk_pin),
        .ps2_data_in (ps2_data_pin),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err)
    );

    int   cyc = 0;
    int   checks = 0, errors = 0;
    int   done_cnt = 0, err_cnt = 0, pulse_cyc = 0, busy_bad = 0;
    logic prev_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: counts done/err cycles and flags busy not dropping with them.
    always @(negedge clk) begin
        if (tx_done === 1'b1) begin
            done_cnt  = done_cnt + 1;
            pulse_cyc = cyc;
            if (busy !== 1'b0 || prev_busy !== 1'b1) busy_bad = busy_bad + 1;
        end
        if (tx_err === 1'b1) begin
            err_cnt   = err_cnt + 1;
            pulse_cyc = cyc;
            if (busy !== 1'b0 || prev_busy !== 1'b1) busy_bad = busy_bad + 1;
        end
        prev_busy = busy;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] exp_frame(input logic [7:0] d);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9]  = (($countones(d) % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic start_tx(input logic [7:0] d);
        @(posedge clk); #1;
        tx_data  = d;
        tx_start = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    // Count cycles of clock-only inhibit and of clock+data overlap.
    task automatic measure_request(output int inh, output int ovl);
        int g;
        g = 0; inh = 0; ovl = 0;
        @(negedge clk);
        while (ps2_clk_oe !== 1'b1 && g < 50) begin @(negedge clk); g++; end
        while (ps2_clk_oe === 1'b1 && ps2_data_oe !== 1'b1 && g < 5000) begin
            inh++; @(negedge clk); g++;
        end
        while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1 && g < 5000) begin
            ovl++; @(negedge clk); g++;
        end
    endtask

    // Keyboard model: samples each bit before the next fall, stop after rise 10,
    // pulls data low for the ack if asked, releases everything at the end.
    task automatic bfm_run(input bit give_ack, input int nclk, output logic [10:0] got, output int fcyc);
        got  = '1;
        fcyc = 0;
        repeat (20) @(negedge clk);
        for (int k = 0; k < nclk; k++) begin
            if (k < 10) got[k] = ps2_data_pin;
            dev_clk_low = 1'b1;
            fcyc = cyc;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            if (k == 9) begin
                repeat (HALF / 2) @(negedge clk);
                got[10] = ps2_data_pin;
                if (give_ack) dev_data_low = 1'b1;
                repeat (HALF / 2) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
        dev_data_low = 1'b0;
    endtask

    task automatic wait_pulse(input int base, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done_cnt + err_cnt != base) seen = 1'b1;
        end
    endtask

    task automatic run_good(input logic [7:0] d, input string tag);
        int          bd, be, bb, inh, ovl, fcyc;
        logic [10:0] got;
        bit          seen;
        bd = done_cnt; be = err_cnt; bb = busy_bad;
        start_tx(d);
        measure_request(inh, ovl);
        check({tag, "_inhibit"}, 32'(inh), 32'(INH));
        check({tag, "_overlap"}, 32'(ovl), 32'd1);
        bfm_run(1'b1, 11, got, fcyc);
        wait_pulse(bd + be, 500, seen);
        check({tag, "_pulse_seen"}, 32'(seen), 32'd1);
        repeat (5) @(negedge clk);
        check({tag, "_frame"}, 32'(got), 32'(exp_frame(d)));
        check({tag, "_byte"}, 32'(got[8:1]), 32'(d));
        check({tag, "_done_cnt"}, 32'(done_cnt - bd), 32'd1);
        check({tag, "_err_cnt"}, 32'(err_cnt - be), 32'd0);
        check({tag, "_busy_edge"}, 32'(busy_bad - bb), 32'd0);
        check({tag, "_idle_outs"}, 32'({ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err}), 32'd0);
        $display("frame %s data=%02h decoded=%03h inhibit=%0d overlap=%0d", tag, d, got, inh, ovl);
    endtask

    initial begin
        int          bd, be, inh, ovl, fcyc, hi;
        logic [10:0] got;
        logic [7:0]  d;
        bit          seen;

        rstin = 1'b0; tx_start = 1'b0; tx_data = 8'h00;
        dev_clk_low = 1'b0; dev_data_low = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset_outs", 32'({ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err}), 32'd0);
        $display("reset outputs=%05b", {ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err});
        @(posedge clk); #1 rstin = 1'b1;
        repeat (10) @(negedge clk);

        // Directed bytes, then random ones.
        run_good(8'hED, "ed");
        run_good(8'hFF, "ff");
        run_good(8'h01, "01");
        run_good(8'h00, "00");
        for (int r = 0; r < 3; r++) begin
            d = 8'($urandom_range(0, 255));
            run_good(d, "rand");
        end

        // No ack on clock 11.
        d = 8'($urandom_range(0, 255));
        bd = done_cnt; be = err_cnt;
        start_tx(d);
        measure_request(inh, ovl);
        bfm_run(1'b0, 11, got, fcyc);
        wait_pulse(bd + be, 500, seen);
        repeat (5) @(negedge clk);
        check("noack_seen", 32'(seen), 32'd1);
        check("noack_err", 32'(err_cnt - be), 32'd1);
        check("noack_done", 32'(done_cnt - bd), 32'd0);
        check("noack_frame", 32'(got), 32'(exp_frame(d)));
        check("noack_outs", 32'({ps2_clk_oe, ps2_data_oe, busy}), 32'd0);
        $display("noack data=%02h err=%0d done=%0d", d, err_cnt - be, done_cnt - bd);

        // Keyboard stops clocking after 4 falls.
        bd = done_cnt; be = err_cnt;
        start_tx(8'hED);
        measure_request(inh, ovl);
        bfm_run(1'b1, 4, got, fcyc);
        wait_pulse(bd + be, 3000, seen);
        repeat (5) @(negedge clk);
        check("tmo_seen", 32'(seen), 32'd1);
        check("tmo_err", 32'(err_cnt - be), 32'd1);
        check("tmo_done", 32'(done_cnt - bd), 32'd0);
        check("tmo_delay", 32'(pulse_cyc - fcyc - COND_LAT), 32'(TMO));
        check("tmo_outs", 32'({ps2_clk_oe, ps2_data_oe, busy}), 32'd0);
        $display("timeout err_after=%0d cycles", pulse_cyc - fcyc - COND_LAT);

        // Second request while busy is ignored.
        bd = done_cnt; be = err_cnt;
        start_tx(8'hF4);
        fork
            begin
                measure_request(inh, ovl);
                bfm_run(1'b1, 11, got, fcyc);
            end
            begin
                repeat (300) @(negedge clk);
                @(posedge clk); #1;
                tx_data = 8'h55; tx_start = 1'b1;
                @(posedge clk); #1;
                tx_start = 1'b0;
            end
        join
        wait_pulse(bd + be, 500, seen);
        hi = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ps2_clk_oe === 1'b1) hi++;
        end
        check("busy_ign_frame", 32'(got), 32'(exp_frame(8'hF4)));
        check("busy_ign_done", 32'(done_cnt - bd), 32'd1);
        check("busy_ign_no_restart", 32'(hi), 32'd0);
        $display("busy_ignore decoded=%03h done=%0d", got, done_cnt - bd);

        // Reset during data bit 5.
        bd = done_cnt; be = err_cnt;
        start_tx(8'h0F);
        measure_request(inh, ovl);
        bfm_run(1'b1, 6, got, fcyc);
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_bit5_oe", 32'(ps2_data_oe), 32'd1);
        @(posedge clk); #1 rstin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_outs", 32'({ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err}), 32'd0);
        #1 rstin = 1'b1;
        repeat (100) @(negedge clk);
        check("mid_rst_no_pulse", 32'((done_cnt - bd) + (err_cnt - be)), 32'd0);
        $display("reset_mid outputs cleared, pulses=%0d", (done_cnt - bd) + (err_cnt - be));
        run_good(8'hFF, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
